mul_unit: RTL and testbench

- Iterative shift-add multiply/multiply-accumulate execute unit for ARM MUL/MLA.
- Sits directly downstream of register_file: takes rd1/rd2 (plus accumulate operand) as operands.
- Produces a 32-bit result plus a one-cycle write-back strobe/address that drives we3/a3/wd3 of register_file.
- busy stalls the pipeline while the multiply runs.

---
 rtl/mul_unit_if.sv | 32 +++
 rtl/mul_unit.sv | 135 +++++++++++++
 tb/tb_mul_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_if.sv
// Operand/result bundle between the issue stage and the iterative multiply unit.
// The master side issues operations; the slave side is the multiply unit itself.
interface mul_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             accumulate;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc_in;
    logic             wb_en;
    logic [3:0]       wb_addr_in;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             wb_we;
    logic [3:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output start, accumulate, op_a, op_b, acc_in, wb_en, wb_addr_in, flush,
        input  busy, done, result, flag_n, flag_z, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  start, accumulate, op_a, op_b, acc_in, wb_en, wb_addr_in, flush,
        output busy, done, result, flag_n, flag_z, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add MUL/MLA unit: one multiplier bit per cycle, WIDTH cycles per op,
// followed by a single DONE cycle that drives the register-file write port.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    mul_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] result_reg;
    logic             flag_n_reg;
    logic             flag_z_reg;
    logic [3:0]       wb_addr_reg;
    logic             wb_en_reg;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_sum;
    logic             last_iter;
    logic             accept;

    // Partial product for this iteration: multiplicand gated by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign acc_sum   = acc_reg + addend;
    assign last_iter = (count_reg == LAST);
    assign accept    = bus.start && !bus.flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.wb_we  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                bus.busy = 1'b1;
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = !bus.flush;
                bus.wb_we  = !bus.flush && wb_en_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
            result_reg  <= '0;
            flag_n_reg  <= 1'b0;
            flag_z_reg  <= 1'b0;
            wb_addr_reg <= '0;
            wb_en_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        mcand_reg   <= bus.op_a;
                        mplier_reg  <= bus.op_b;
                        acc_reg     <= bus.accumulate ? bus.acc_in : '0;
                        count_reg   <= '0;
                        wb_addr_reg <= bus.wb_addr_in;
                        wb_en_reg   <= bus.wb_en;
                    end
                end
                MUL: begin
                    if (!bus.flush) begin
                        acc_reg    <= acc_sum;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        count_reg  <= count_reg + 1'b1;
                        // The final accumulation is published straight from the adder.
                        if (last_iter) begin
                            result_reg <= acc_sum;
                            flag_n_reg <= acc_sum[WIDTH-1];
                            flag_z_reg <= (acc_sum == '0);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result  = result_reg;
    assign bus.wb_data = result_reg;
    assign bus.flag_n  = flag_n_reg;
    assign bus.flag_z  = flag_z_reg;
    assign bus.wb_addr = wb_addr_reg;

endmodule

// File: tb/tb_mul_unit.sv
// Randomised and directed bench for mul_unit, checked against an arithmetic model
// of MUL/MLA (low word of a*b [+c]) and the documented cycle timing.
module tb_mul_unit;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mul_unit_if #(.WIDTH(WIDTH)) bus_if ();

    mul_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_result;
    logic             exp_wen;
    logic [3:0]       exp_addr;
    logic [WIDTH-1:0] last_result = '0;
    logic             last_n = 1'b0;
    logic             last_z = 1'b0;
    int               cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, b, c, input bit accum);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b} + (accum ? {32'd0, c} : 64'd0);
        return full[WIDTH-1:0];
    endfunction

    // Drives one start pulse (sampled at the next rising edge) and records the expectation.
    task automatic launch(input logic [WIDTH-1:0] a, b, c, input bit accum, wen, input logic [3:0] addr);
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.op_a       = a;
        bus_if.op_b       = b;
        bus_if.acc_in     = c;
        bus_if.accumulate = accum;
        bus_if.wb_en      = wen;
        bus_if.wb_addr_in = addr;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        exp_result   = model(a, b, c, accum);
        exp_wen      = wen;
        exp_addr     = addr;
        cyc          = 0;
        $display("op a=%08h b=%08h c=%08h mla=%0d wen=%0d addr=%0d expect=%08h",
                 a, b, c, accum, wen, addr, exp_result);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Waits for done, checking latency, result, flags and write-back fields.
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        while (!seen && cyc < LAT + 20) begin
            if (bus_if.busy !== 1'b1) begin
                check("busy_during_op", {63'd0, bus_if.busy}, 64'd1);
                break;
            end
            step();
            if (bus_if.done === 1'b1) seen = 1'b1;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        if (seen) begin
            check("latency", cyc, LAT);
            check("result", bus_if.result, exp_result);
            check("wb_data", bus_if.wb_data, exp_result);
            check("flag_n", bus_if.flag_n, exp_result[WIDTH-1]);
            check("flag_z", bus_if.flag_z, exp_result == '0);
            check("wb_we", bus_if.wb_we, exp_wen);
            check("wb_addr", bus_if.wb_addr, exp_addr);
            last_result = exp_result;
            last_n      = exp_result[WIDTH-1];
            last_z      = (exp_result == '0);
            step();
            check("done_one_cycle", {63'd0, bus_if.done}, 64'd0);
            check("idle_after", {63'd0, bus_if.busy}, 64'd0);
            check("result_held", bus_if.result, exp_result);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus_if.busy, 0);
        check({tag, "_done"}, bus_if.done, 0);
        check({tag, "_wb_we"}, bus_if.wb_we, 0);
        check({tag, "_result"}, bus_if.result, 0);
        check({tag, "_flags"}, {bus_if.flag_n, bus_if.flag_z}, 0);
        check({tag, "_wb_addr"}, bus_if.wb_addr, 0);
    endtask

    initial begin
        int pulses;
        int we_pulses;
        logic [WIDTH-1:0] ra, rb, rc;

        bus_if.start      = 1'b0;
        bus_if.accumulate = 1'b0;
        bus_if.op_a       = '0;
        bus_if.op_b       = '0;
        bus_if.acc_in     = '0;
        bus_if.wb_en      = 1'b0;
        bus_if.wb_addr_in = '0;
        bus_if.flush      = 1'b0;

        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("post_reset");

        // Directed cases.
        launch(32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 4'd4);
        wait_done();
        launch(32'hFFFF_FFFF, 32'd2, 32'd3, 1'b1, 1'b1, 4'd7);
        wait_done();
        launch(32'd0, 32'h1234, 32'd0, 1'b0, 1'b1, 4'd1);
        wait_done();
        launch(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 4'd9);
        wait_done();

        // Back-to-back: next start on the first IDLE cycle after DONE.
        launch(32'd100, 32'd200, 32'd55, 1'b1, 1'b1, 4'd2);
        wait_done();
        launch(32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1, 1'b0, 1'b1, 4'd3);
        wait_done();

        // Randomised operations; operands change after start to show they are not re-sampled.
        for (int i = 0; i < 20; i++) begin
            ra = (i % 4 == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom;
            rb = (i % 5 == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom;
            rc = $urandom;
            launch(ra, rb, rc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)));
            bus_if.op_a   = $urandom;
            bus_if.op_b   = $urandom;
            bus_if.acc_in = $urandom;
            wait_done();
        end

        // start while busy is ignored.
        launch(32'd12, 32'd11, 32'd0, 1'b0, 1'b1, 4'd5);
        while (cyc < 9) step();
        bus_if.start = 1'b1;
        bus_if.op_a  = 32'd1000;
        bus_if.op_b  = 32'd1000;
        step();
        bus_if.start = 1'b0;
        wait_done();
        pulses = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            step();
            if (bus_if.done === 1'b1) pulses++;
            if (bus_if.busy === 1'b1) pulses++;
        end
        check("no_queued_op", pulses, 0);

        // Flush mid-operation: no completion, outputs held, then a normal op.
        launch(32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 4'd6);
        while (cyc < 14) step();
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        check("flush_busy", bus_if.busy, 0);
        pulses = 0;
        we_pulses = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            if (bus_if.done === 1'b1) pulses++;
            if (bus_if.wb_we === 1'b1) we_pulses++;
            step();
        end
        check("flush_no_done", pulses, 0);
        check("flush_no_we", we_pulses, 0);
        check("flush_result_held", bus_if.result, last_result);
        check("flush_flags_held", {bus_if.flag_n, bus_if.flag_z}, {last_n, last_z});
        launch(32'd21, 32'd2, 32'd0, 1'b0, 1'b1, 4'd8);
        wait_done();

        // Flush in IDLE blocks a start.
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.flush = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.flush = 1'b0;
        check("idle_flush_blocks_start", bus_if.busy, 0);

        // Asynchronous reset mid-operation.
        launch(32'd123, 32'd456, 32'd0, 1'b0, 1'b1, 4'd11);
        while (cyc < 19) step();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        last_result = '0;
        @(negedge clk);
        reset_n = 1'b1;
        launch(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'd12);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
